// File: rtl/execute_pkg.sv
`default_nettype none
// ============================================================================
// Module  : execute_pkg
// Brief   : Shared types and constants for the execute-stage hazard sequencer.
// Revision: 1.0
// ============================================================================
package execute_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t HZ_NOP = '{
        pc_write:      1'b1,
        if_id_write:   1'b1,
        if_id_flush:   1'b0,
        id_ex_write:   1'b1,
        id_ex_flush:   1'b0,
        ex_mem_bubble: 1'b0
    };

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that sticks at all-ones instead of wrapping.
// Revision: 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ex_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ex_hazard_sequencer
// Brief   : Pipeline stall/flush controller for load-use, branch and mul/div.
// Revision: 1.0
// ============================================================================
module ex_hazard_sequencer
    import execute_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_uses_rs1,
    input  logic             if_id_uses_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_valid,
    input  logic             take_branch,
    input  logic             ex_mc_op,
    input  logic             mc_done,
    output logic             mc_start,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             mc_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int              TMR_W    = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MC_TIMEOUT - 1);

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic             r_err;
    hz_ctrl_t         w_ctrl;
    logic             w_start;
    logic             w_lu;
    logic             w_timer_clr;
    logic             w_timer_inc;
    logic             w_err_set;
    logic             w_stall_inc;
    logic             w_flush_inc;

    always_comb begin
        w_lu = id_ex_valid && id_ex_mem_read && (id_ex_rd != 5'd0) &&
               ((if_id_uses_rs1 && (if_id_rs1 == id_ex_rd)) ||
                (if_id_uses_rs2 && (if_id_rs2 == id_ex_rd)));
    end

    always_comb begin
        w_ctrl      = HZ_NOP;
        w_start     = 1'b0;
        w_state_nxt = r_state;
        w_timer_clr = 1'b0;
        w_timer_inc = 1'b0;
        w_err_set   = 1'b0;
        w_flush_inc = 1'b0;
        case (r_state)
            IDLE: begin
                if (take_branch) begin
                    w_ctrl.if_id_flush = 1'b1;
                    w_ctrl.id_ex_flush = 1'b1;
                    w_flush_inc        = 1'b1;
                end else if (ex_mc_op && id_ex_valid) begin
                    w_start              = 1'b1;
                    w_ctrl.pc_write      = 1'b0;
                    w_ctrl.if_id_write   = 1'b0;
                    w_ctrl.id_ex_write   = 1'b0;
                    w_ctrl.ex_mem_bubble = 1'b1;
                    w_timer_clr          = 1'b1;
                    w_state_nxt          = MC_BUSY;
                end else if (w_lu) begin
                    w_ctrl.pc_write    = 1'b0;
                    w_ctrl.if_id_write = 1'b0;
                    w_ctrl.id_ex_flush = 1'b1;
                end
            end
            MC_BUSY: begin
                // Done beats timeout when both land on the same cycle.
                if (mc_done) begin
                    w_state_nxt = IDLE;
                end else if (r_timer == TMR_LAST) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_ctrl.pc_write      = 1'b0;
                    w_ctrl.if_id_write   = 1'b0;
                    w_ctrl.id_ex_write   = 1'b0;
                    w_ctrl.ex_mem_bubble = 1'b1;
                    w_timer_inc          = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (reset) begin
            w_ctrl  = HZ_NOP;
            w_start = 1'b0;
        end
        // The release cycle of a multi-cycle op still occupies EX, so it counts.
        w_stall_inc = !w_ctrl.pc_write || (r_state == MC_BUSY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (w_timer_inc) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .clr   (1'b0),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flush_inc),
        .clr   (1'b0),
        .count (flush_events)
    );

    assign mc_start       = w_start;
    assign pc_write       = w_ctrl.pc_write;
    assign if_id_write    = w_ctrl.if_id_write;
    assign if_id_flush    = w_ctrl.if_id_flush;
    assign id_ex_write    = w_ctrl.id_ex_write;
    assign id_ex_flush    = w_ctrl.id_ex_flush;
    assign ex_mem_bubble  = w_ctrl.ex_mem_bubble;
    assign mc_timeout_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ex_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_hazard_sequencer
// Brief   : Directed plus randomized checks against a cycle-level behaviour model.
// Revision: 1.0
// ============================================================================
module tb_ex_hazard_sequencer;

    localparam int MC_TIMEOUT = 8;
    localparam int CNT_W      = 4;
    localparam int MAXC       = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       if_id_rs1, if_id_rs2, id_ex_rd;
    logic             if_id_uses_rs1, if_id_uses_rs2;
    logic             id_ex_mem_read, id_ex_valid, take_branch, ex_mc_op, mc_done;
    logic             mc_start, pc_write, if_id_write, if_id_flush;
    logic             id_ex_write, id_ex_flush, ex_mem_bubble, mc_timeout_err;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int vectors     = 0;
    int miscompares = 0;

    // Behaviour model: busy flag, cycles since mc_start, sticky error, counts.
    bit m_busy;
    int m_age;
    bit m_err;
    int m_stall;
    int m_flush;

    ex_hazard_sequencer #(.MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read), .id_ex_valid(id_ex_valid),
        .take_branch(take_branch), .ex_mc_op(ex_mc_op), .mc_done(mc_done),
        .mc_start(mc_start), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
        .ex_mem_bubble(ex_mem_bubble), .mc_timeout_err(mc_timeout_err),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < MAXC) ? v + 1 : v;
    endfunction

    // {mc_start, pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble}
    function automatic logic [6:0] outs();
        return {mc_start, pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble};
    endfunction

    task automatic check_regs();
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        chk("flush_events", 32'(flush_events), 32'(m_flush));
        chk("timeout_err", 32'(mc_timeout_err), 32'(m_err));
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model.
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic mr, input logic v,
                        input logic tb, input logic mc, input logic done);
        bit         lu;
        logic [6:0] exp;
        if_id_rs1 = rs1; if_id_rs2 = rs2; if_id_uses_rs1 = u1; if_id_uses_rs2 = u2;
        id_ex_rd = rd; id_ex_mem_read = mr; id_ex_valid = v;
        take_branch = tb; ex_mc_op = mc; mc_done = done;
        @(negedge clk);
        check_regs();
        lu  = v && mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        exp = 7'b0110100;
        if (!m_busy) begin
            if (tb) begin
                exp = 7'b0111110;
                m_flush = sat_inc(m_flush);
            end else if (mc && v) begin
                exp = 7'b1000001;
                m_stall = sat_inc(m_stall);
                m_busy = 1; m_age = 1;
            end else if (lu) begin
                exp = 7'b0000110;
                m_stall = sat_inc(m_stall);
            end
        end else begin
            m_stall = sat_inc(m_stall);
            if (done || m_age == MC_TIMEOUT) begin
                if (!done) m_err = 1;
                m_busy = 0;
            end else begin
                exp = 7'b0000001;
                m_age++;
            end
        end
        chk("ctrl_outputs", 32'(outs()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset asserted mid-cycle with hazard-provoking inputs: outputs must be no-hazard.
    task automatic apply_reset(input logic mc);
        reset = 1'b1;
        ex_mc_op = mc; id_ex_valid = 1'b1; take_branch = 1'b0;
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd3; if_id_rs1 = 5'd3; if_id_uses_rs1 = 1'b1;
        mc_done = 1'b0;
        m_busy = 0; m_age = 0; m_err = 0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        chk("reset_ctrl", 32'(outs()), 32'(7'b0110100));
        check_regs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        if_id_rs1 = '0; if_id_rs2 = '0; if_id_uses_rs1 = 0; if_id_uses_rs2 = 0;
        id_ex_rd = '0; id_ex_mem_read = 0; id_ex_valid = 0;
        take_branch = 0; ex_mc_op = 0; mc_done = 0;
        @(posedge clk);
        #1;
        apply_reset(1'b0);

        // Load x5, then add x6,x5,x1 in ID: single stall cycle.
        step(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_step();
        // rd = x0, and rs1 match without uses_rs1: no stall.
        step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(5'd5, 5'd1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // rs2 match.
        step(5'd2, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_step();

        // Branch beats load-use in the same cycle.
        apply_reset(1'b0);
        step(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_step();

        // Multi-cycle op, done four cycles after start; branch while busy ignored.
        apply_reset(1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle_step();
        idle_step();

        // Timeout: done never arrives; branches and load-use while busy ignored.
        apply_reset(1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < MC_TIMEOUT; i++)
            step(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'(i % 2), 1'b1, 1'b0);
        idle_step();
        idle_step();

        // Reset during the second busy cycle; no restart while ex_mc_op is low.
        apply_reset(1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        apply_reset(1'b1);
        for (int i = 0; i < 3; i++)
            step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Saturation of the stall counter.
        for (int i = 0; i < 20; i++)
            step(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_step();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 97) == 0) apply_reset(1'($urandom % 2));
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom % 2), 1'($urandom % 2), 5'($urandom_range(0, 3)),
                 1'($urandom % 2), 1'(($urandom % 4) != 0), 1'(($urandom % 5) == 0),
                 1'(($urandom % 6) == 0), 1'(($urandom % 6) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
